// File: rtl/exhaustive_error_eval.sv
// Exhaustive lock-step evaluator: sweeps every N_IN-bit pattern into an exact and an
// approximate netlist and accumulates mismatch count, Hamming sum, max |error| and a MISR.
module exhaustive_error_eval #(
  parameter int N_IN  = 7,
  parameter int N_OUT = 4,
  parameter int LAT   = 0,
  parameter int SIG_W = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic                                 abort,
  output logic [N_IN-1:0]                      pat_o,
  input  logic [N_OUT-1:0]                     po_exact_i,
  input  logic [N_OUT-1:0]                     po_approx_i,
  output logic                                 busy,
  output logic                                 done,
  output logic [N_IN:0]                        err_count,
  output logic [N_IN+$clog2(N_OUT+1)-1:0]      ham_sum,
  output logic [N_OUT-1:0]                     max_abs_err,
  output logic [SIG_W-1:0]                     signature
);

  localparam int PC_W  = $clog2(N_OUT+1);
  localparam int HAM_W = N_IN + PC_W;
  localparam logic [N_IN:0] LAST_PAT = {1'b0, {N_IN{1'b1}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic [PC_W-1:0] popcount(input logic [N_OUT-1:0] v);
    logic [PC_W-1:0] pc;
    pc = '0;
    for (int i = 0; i < N_OUT; i++) begin
      pc = pc + PC_W'(v[i]);
    end
    return pc;
  endfunction

  function automatic logic [N_OUT-1:0] abs_diff(input logic [N_OUT-1:0] a,
                                                input logic [N_OUT-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig,
                                                 input logic [N_OUT-1:0] d);
    logic [SIG_W-1:0] fb;
    fb = sig[SIG_W-1] ? SIG_W'(32'h0040_0007) : SIG_W'(32'h0000_0000);
    return {sig[SIG_W-2:0], 1'b0} ^ fb ^ SIG_W'(d);
  endfunction

  state_e          state_q, state_d;
  logic [N_IN:0]   cnt_q, cnt_d;
  logic [3:0]      dcnt_q, dcnt_d;
  logic            busy_q, done_q;
  logic [N_IN:0]   err_q;
  logic [HAM_W-1:0] ham_q;
  logic [N_OUT-1:0] max_q;
  logic [SIG_W-1:0] sig_q;

  logic             go_s;
  logic             run_s;
  logic             sample_v_s;
  logic             acc_en_s;
  logic [N_OUT-1:0] diff_s;
  logic [N_OUT-1:0] absd_s;

  assign run_s  = (state_q == RUN);
  assign go_s   = start && !abort && ((state_q == IDLE) || (state_q == DONE));
  assign diff_s = po_exact_i ^ po_approx_i;
  assign absd_s = abs_diff(po_exact_i, po_approx_i);
  // A sample landing on an aborting edge is dropped so the partial results stay frozen.
  assign acc_en_s = sample_v_s && !abort;

  generate
    if (LAT == 0) begin : g_comb
      assign sample_v_s = run_s;
    end else begin : g_pipe
      logic [LAT-1:0] tag_q;

      // Valid-tag shift register tracking which cycles carry a pattern's outputs.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tag_q <= '0;
        end else if (abort) begin
          tag_q <= '0;
        end else begin
          tag_q[0] <= run_s;
          for (int i = 1; i < LAT; i++) begin
            tag_q[i] <= tag_q[i-1];
          end
        end
      end

      assign sample_v_s = tag_q[LAT-1];
    end
  endgenerate

  // Sweep sequencing: abort dominates, start only honoured when not busy.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      dcnt_d  = 4'd0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            state_d = state_q;
          end
        end
        RUN: begin
          if (cnt_q == LAST_PAT) begin
            state_d = (LAT > 0) ? DRAIN : DONE;
            dcnt_d  = 4'd0;
          end else begin
            cnt_d = cnt_q + (N_IN+1)'(1);
          end
        end
        DRAIN: begin
          if (dcnt_q == 4'(LAT-1)) begin
            state_d = DONE;
          end else begin
            dcnt_d = dcnt_q + 4'd1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Control registers and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dcnt_q  <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      busy_q  <= (state_d == RUN) || (state_d == DRAIN);
      done_q  <= (state_d == DONE);
    end
  end

  // Error metric accumulators and approximate-output signature.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
      ham_q <= '0;
      max_q <= '0;
      sig_q <= '0;
    end else if (go_s) begin
      err_q <= '0;
      ham_q <= '0;
      max_q <= '0;
      sig_q <= '0;
    end else if (acc_en_s) begin
      err_q <= err_q + (N_IN+1)'(diff_s != '0);
      ham_q <= ham_q + HAM_W'(popcount(diff_s));
      max_q <= (absd_s > max_q) ? absd_s : max_q;
      sig_q <= misr_step(sig_q, po_approx_i);
    end else begin
      err_q <= err_q;
      ham_q <= ham_q;
      max_q <= max_q;
      sig_q <= sig_q;
    end
  end

  assign pat_o       = cnt_q[N_IN-1:0];
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_count   = err_q;
  assign ham_sum     = ham_q;
  assign max_abs_err = max_q;
  assign signature   = sig_q;

endmodule

// File: tb/tb_exhaustive_error_eval.sv
// Directed bench: a LAT=0 instance fed combinationally and a LAT=2 instance fed through
// two bench registers, with metrics checked against hand values and a MISR model.
module tb_exhaustive_error_eval;

  logic        clk;
  logic        rst_n;
  logic        start0, abort0, start2, abort2;
  int          mode;

  logic [6:0]  pat0, pat2;
  logic [3:0]  ex0, ap0, ex2_d1, ap2_d1, ex2_d2, ap2_d2;
  logic        busy0, done0, busy2, done2;
  logic [7:0]  err0, err2;
  logic [9:0]  ham0, ham2;
  logic [3:0]  max0, max2;
  logic [31:0] sig0, sig2;

  int errors = 0;
  int checks = 0;

  function automatic logic [3:0] approx_f(input int m, input logic [3:0] e);
    case (m)
      0:       return e;
      1:       return e ^ 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] sig_model(input int m);
    logic [31:0] s;
    logic [3:0]  a;
    s = 32'h0;
    for (int p = 0; p < 128; p++) begin
      a = approx_f(m, p[3:0]);
      s = {s[30:0], 1'b0} ^ (s[31] ? 32'h0040_0007 : 32'h0) ^ {28'h0, a};
    end
    return s;
  endfunction

  assign ex0 = pat0[3:0];
  assign ap0 = approx_f(mode, pat0[3:0]);

  always @(posedge clk) begin
    ex2_d1 <= pat2[3:0];
    ap2_d1 <= approx_f(mode, pat2[3:0]);
    ex2_d2 <= ex2_d1;
    ap2_d2 <= ap2_d1;
  end

  exhaustive_error_eval #(.N_IN(7), .N_OUT(4), .LAT(0), .SIG_W(32)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .pat_o(pat0),
    .po_exact_i(ex0), .po_approx_i(ap0), .busy(busy0), .done(done0),
    .err_count(err0), .ham_sum(ham0), .max_abs_err(max0), .signature(sig0)
  );

  exhaustive_error_eval #(.N_IN(7), .N_OUT(4), .LAT(2), .SIG_W(32)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .pat_o(pat2),
    .po_exact_i(ex2_d2), .po_approx_i(ap2_d2), .busy(busy2), .done(done2),
    .err_count(err2), .ham_sum(ham2), .max_abs_err(max2), .signature(sig2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulses start on the chosen instance and counts busy cycles until done (bounded).
  // With glitch set, extra start pulses are injected mid-run.
  task automatic sweep(input bit use2, input bit glitch, output int bc);
    bc = 0;
    @(negedge clk);
    if (use2) start2 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start2 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (use2 ? done2 : done0) break;
      if (use2 ? busy2 : busy0) bc++;
      if (glitch && (bc == 20 || bc == 60)) start0 = 1'b1; else start0 = 1'b0;
      @(negedge clk);
    end
    start0 = 1'b0;
    check(use2 ? "sweep_done2" : "sweep_done0", 64'(use2 ? done2 : done0), 64'd1);
  endtask

  int          bc;
  logic [31:0] sig_t2;
  bit          found;

  initial begin
    rst_n = 1'b0; start0 = 1'b0; abort0 = 1'b0; start2 = 1'b0; abort2 = 1'b0;
    mode = 0;
    repeat (3) @(negedge clk);
    check("rst_pat",  64'(pat0),  64'd0);
    check("rst_busy", 64'(busy0), 64'd0);
    check("rst_done", 64'(done0), 64'd0);
    check("rst_err",  64'(err0),  64'd0);
    check("rst_ham",  64'(ham0),  64'd0);
    check("rst_max",  64'(max0),  64'd0);
    check("rst_sig",  64'(sig0),  64'd0);
    rst_n = 1'b1;

    // Test 1: identical outputs
    mode = 0;
    sweep(1'b0, 1'b0, bc);
    check("t1_busy_cycles", 64'(bc),   64'd128);
    check("t1_err",         64'(err0), 64'd0);
    check("t1_ham",         64'(ham0), 64'd0);
    check("t1_max",         64'(max0), 64'd0);
    check("t1_sig",         64'(sig0), 64'(sig_model(0)));
    check("t1_pat_last",    64'(pat0), 64'd127);

    // Test 2: LSB flipped on every pattern
    mode = 1;
    sweep(1'b0, 1'b0, bc);
    check("t2_busy_cycles", 64'(bc),   64'd128);
    check("t2_err",         64'(err0), 64'd128);
    check("t2_ham",         64'(ham0), 64'd128);
    check("t2_max",         64'(max0), 64'd1);
    check("t2_sig",         64'(sig0), 64'(sig_model(1)));
    sig_t2 = sig0;

    // Test 3: approximate output stuck at zero
    mode = 2;
    sweep(1'b0, 1'b0, bc);
    check("t3_err",  64'(err0), 64'd120);
    check("t3_ham",  64'(ham0), 64'd256);
    check("t3_max",  64'(max0), 64'd15);
    check("t3_sig",  64'(sig0), 64'(sig_model(2)));
    check("t3_done", 64'(done0), 64'd1);

    // Test 4: LAT=2 instance with test 2 data
    mode = 1;
    sweep(1'b1, 1'b0, bc);
    check("t4_busy_cycles", 64'(bc),   64'd130);
    check("t4_err",         64'(err2), 64'd128);
    check("t4_ham",         64'(ham2), 64'd128);
    check("t4_max",         64'(max2), 64'd1);
    check("t4_sig_vs_t2",   64'(sig2), 64'(sig_t2));
    check("t4_sig_model",   64'(sig2), 64'(sig_model(1)));

    // Test 5: abort at pattern 50, then a full run with ignored start pulses
    mode = 1;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (pat0 == 7'd50) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("t5_reached_50", 64'(found), 64'd1);
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    check("t5_busy",  64'(busy0), 64'd0);
    check("t5_done",  64'(done0), 64'd0);
    check("t5_pat",   64'(pat0),  64'd0);
    check("t5_err",   64'(err0),  64'd50);
    check("t5_ham",   64'(ham0),  64'd50);
    repeat (3) @(negedge clk);
    check("t5_err_hold", 64'(err0), 64'd50);
    check("t5_idle",     64'(busy0), 64'd0);
    sweep(1'b0, 1'b1, bc);
    check("t5_busy_cycles", 64'(bc),   64'd128);
    check("t5_err_full",    64'(err0), 64'd128);
    check("t5_ham_full",    64'(ham0), 64'd128);
    check("t5_sig_full",    64'(sig0), 64'(sig_t2));

    // Test 6: asynchronous reset mid-sweep
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (pat0 == 7'd70) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("t6_reached_70", 64'(found), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_pat",  64'(pat0),  64'd0);
    check("t6_busy", 64'(busy0), 64'd0);
    check("t6_err",  64'(err0),  64'd0);
    check("t6_ham",  64'(ham0),  64'd0);
    check("t6_sig",  64'(sig0),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("t6_idle_busy", 64'(busy0), 64'd0);
    check("t6_idle_done", 64'(done0), 64'd0);
    check("t6_idle_pat",  64'(pat0),  64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exhaustive_error_eval.md
Name: exhaustive_error_eval

Overview:
- Hardware exhaustive evaluator for partitioned subcircuits.
- Sweeps every input pattern of an N_IN-bit cut.
- Drives the exact and the approximate netlists in lock-step and compares their outputs.
- Accumulates the error metrics used in approximation scoring, plus an output signature. Replaces the simulation-only enumerate-and-print flow with a synthesizable, latency-aware engine.

Parameters:
- N_IN, 7, input width of the subcircuit; sweeps 2^N_IN patterns.
- N_OUT, 4, output width of the subcircuit.
- LAT, 0, pipeline latency of the DUTs in cycles (0..8); 0 means combinational.
- SIG_W, 32, MISR signature width (fixed polynomial below; only 32 supported).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  start pulse, honoured in IDLE or DONE only.
- abort  in  1  stop the sweep, return to IDLE.
- pat_o  out  N_IN  pattern driven to both DUTs.
- po_exact_i  in  N_OUT  exact DUT output.
- po_approx_i  in  N_OUT  approximate DUT output.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  level, high in DONE.
- err_count  out  N_IN+1  number of patterns with any output mismatch.
- ham_sum  out  N_IN+$clog2(N_OUT+1)  total Hamming distance over all patterns.
- max_abs_err  out  N_OUT  max |exact-approx|, both operands unsigned.
- signature  out  SIG_W  MISR over po_approx_i.

Behaviour:
- Reset: state IDLE; all outputs 0.
- Reset is asynchronous and may be asserted at any time, mid-sweep included; it clears everything.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start: on the next edge enter RUN. That same edge clears err_count, ham_sum, max_abs_err and signature, and sets pat_o=0.
- RUN: pat_o increments by 1 each cycle, 0 .. 2^N_IN-1.
  - Use an internal N_IN+1-bit counter so the terminal pattern is detected without wrap ambiguity.
  - After the cycle presenting 2^N_IN-1, go to RUN->DRAIN if LAT>0, else RUN->DONE.
  - pat_o holds the last pattern through DRAIN.
- DRAIN: lasts exactly LAT cycles, then DRAIN->DONE.
- Sampling:
  - A valid tag shift register of depth LAT follows each pattern.
  - The outputs for pattern k are sampled in cycle k+LAT counted from the first RUN cycle.
  - Only tagged cycles accumulate; the first LAT cycles of RUN accumulate nothing.
- Per sample, with d = po_exact_i ^ po_approx_i:
  - err_count += (d != 0).
  - ham_sum += popcount(d).
  - max_abs_err = max(max_abs_err, |exact - approx|).
  - signature = {sig[30:0],1'b0} ^ (sig[31] ? 32'h0040_0007 : 0) ^ zero-extended po_approx_i.
- No saturation is needed: widths cover the worst case (err_count ≤ 2^N_IN, ham_sum ≤ N_OUT·2^N_IN).
- Timing: all accumulators update on the edge closing the sample cycle. done rises on the same edge as the final update, so results are stable whenever done=1.
- busy is high for exactly 2^N_IN+LAT cycles.
- done stays high until a start or an abort.
- start while busy: ignored.
- abort (any state):
  - next edge goes to IDLE; busy=0, done=0, pat_o=0.
  - Accumulators hold their partial values.
  - The pipeline tags flush, so no late sample accumulates.
- abort and start in the same cycle: abort wins.
- Outputs from DUTs are assumed stable only in sampled cycles; unsampled values are don't-care.

Test Plan:
1. Defaults; po_approx_i tied to po_exact_i = pat_o[3:0]; pulse start -> busy high for 128 cycles; done=1; err_count=0, ham_sum=0, max_abs_err=0.
2. po_exact_i = pat_o[3:0], po_approx_i = pat_o[3:0]^4'b0001 -> err_count=128, ham_sum=128, max_abs_err=1.
3. po_exact_i = pat_o[3:0], po_approx_i = 0 -> err_count=120, ham_sum=256, max_abs_err=15; signature matches the bench reference model.
4. LAT=2, both outputs delayed by two registers, data as in test 2 -> busy high 130 cycles; same metrics as test 2; same signature as test 2 run with LAT=0.
5. Abort when pat_o=50 -> next cycle IDLE, busy=0, done=0, err_count frozen at 50 (test 2 data). Then start -> full test 2 results; start pulses during that run are ignored.
6. Assert rst_n low at pat_o=70 -> all outputs 0 immediately. After release, stay IDLE with pat_o=0 until start.
